// File: rtl/tmp_seq_ctrl_pkg.sv
// rtl/tmp_seq_ctrl_pkg.sv - shared types and default timing for the temperature-sensor sequencer
// Purpose: state encoding for the sequencer FSM, default timing constants and a small
//          helper used to size the shared phase timer.
// Ports:   none (package).
package tmp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_BLANK,
    ST_SMALL,
    ST_BIG,
    ST_DONE
  } tmp_state_t;

  localparam int DEF_PRECHG_CYC = 11;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_BLANK_CYC  = 1;
  localparam int DEF_N_CONV     = 64;
  localparam int DEF_NCH        = 1;
  localparam int DEF_CONT       = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tmp_seq_ctrl_if.sv
// rtl/tmp_seq_ctrl_if.sv - analog front end / readout signal bundle of the sequencer
// Purpose: groups the comparator input, enable, switch controls and result strobe.
// Ports:   master - sequencer side (drives switches and result, reads en/cmp)
//          slave  - front end / readout side (drives en/cmp, reads the rest)
interface tmp_seq_ctrl_if #(
  parameter int NCH    = 1,
  parameter int N_CONV = 64
);
  localparam int RW = $clog2(N_CONV + 1);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           en;
  logic           cmp;
  logic [NCH-1:0] ch_sel;
  logic           pre_chrg;
  logic           phi_s;
  logic           phi_b;
  logic           cmp_p1;
  logic           cmp_p2;
  logic           src_n;
  logic           snk;
  logic           busy;
  logic           valid;
  logic [RW-1:0]  result;
  logic [CW-1:0]  result_ch;

  modport master (
    input  en, cmp,
    output ch_sel, pre_chrg, phi_s, phi_b, cmp_p1, cmp_p2, src_n, snk,
           busy, valid, result, result_ch
  );

  modport slave (
    output en, cmp,
    input  ch_sel, pre_chrg, phi_s, phi_b, cmp_p1, cmp_p2, src_n, snk,
           busy, valid, result, result_ch
  );

endinterface

// File: rtl/tmp_seq_ctrl_phase_timer.sv
// rtl/tmp_seq_ctrl_phase_timer.sv - loadable down-counter timing every sequencer phase
// Purpose: loaded with (duration-1) on phase entry; last_o flags the final cycle of the phase.
// Ports:   clk, reset   - clock, synchronous active-high reset
//          load_i       - load load_val_i this edge
//          load_val_i   - phase duration minus one
//          last_o       - counter has reached zero (last cycle of the phase)
module tmp_phase_timer #(
  parameter int  MAX_LOAD = 11,
  localparam int TW       = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          last_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/tmp_seq_ctrl.sv
// rtl/tmp_seq_ctrl.sv - temperature-sensor phase sequencer with charge-balance counting
// Purpose: sequences precharge, break-before-make small/big diode phases and src/snk
//          balance pulses; counts comparator ones over N_CONV cycles per conversion and
//          round-robins NCH channels.
// Ports:   clk, reset - clock, synchronous active-high reset
//          bus        - tmp_seq_ctrl_if.master: en/cmp in; ch_sel, pre_chrg, phi_s, phi_b,
//                       cmp_p1/cmp_p2, src_n, snk, busy, valid, result, result_ch out
module tmp_seq_ctrl
  import tmp_seq_pkg::*;
#(
  parameter int PRECHG_CYC = DEF_PRECHG_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int N_CONV     = DEF_N_CONV,
  parameter int NCH        = DEF_NCH,
  parameter int CONT       = DEF_CONT
) (
  input  logic           clk,
  input  logic           reset,
  tmp_seq_ctrl_if.master bus
);

  localparam int RW   = $clog2(N_CONV + 1);
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW   = $clog2(N_CONV);
  localparam int MAXL = max3(PRECHG_CYC, SETTLE_CYC, BLANK_CYC);
  localparam int TW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  tmp_state_t     state_q, state_d, nxt_q, nxt_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic [RW-1:0]  ones_q, ones_d;
  logic [CW-1:0]  ch_idx_q, ch_idx_d;
  logic [NCH-1:0] ch_sel_q, ch_sel_d;
  logic           pre_q, pre_d, phi_s_q, phi_s_d, phi_b_q, phi_b_d;
  logic           p1_q, p1_d, p2_q, p2_d, src_n_q, src_n_d, snk_q, snk_d;
  logic           busy_q, busy_d, valid_q, valid_d;
  logic [RW-1:0]  result_q, result_d;
  logic [CW-1:0]  result_ch_q, result_ch_d;
  logic           last, load, sample;
  logic [TW-1:0]  load_val;

  tmp_phase_timer #(.MAX_LOAD(MAXL)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .last_o     (last)
  );

  // The comparator decision is taken only on the final BIG cycle.
  assign sample = (state_q == ST_BIG) && last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      nxt_q       <= ST_SMALL;
      iter_q      <= '0;
      ones_q      <= '0;
      ch_idx_q    <= '0;
      ch_sel_q    <= NCH'(1);
      pre_q       <= 1'b0;
      phi_s_q     <= 1'b0;
      phi_b_q     <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b1;
      src_n_q     <= 1'b1;
      snk_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      iter_q      <= iter_d;
      ones_q      <= ones_d;
      ch_idx_q    <= ch_idx_d;
      ch_sel_q    <= ch_sel_d;
      pre_q       <= pre_d;
      phi_s_q     <= phi_s_d;
      phi_b_q     <= phi_b_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      src_n_q     <= src_n_d;
      snk_q       <= snk_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    iter_d  = iter_q;
    ones_d  = ones_q;
    unique case (state_q)
      ST_IDLE:      if (bus.en) state_d = ST_PRECHARGE;
      ST_PRECHARGE: if (last) begin state_d = ST_BLANK; nxt_d = ST_SMALL; end
      ST_BLANK:     if (last) state_d = nxt_q;
      ST_SMALL:     if (last) begin state_d = ST_BLANK; nxt_d = ST_BIG; end
      ST_BIG: begin
        if (last) begin
          if (bus.cmp) ones_d = ones_q + 1'b1;
          iter_d = iter_q + 1'b1;
          if (iter_q == IW'(N_CONV - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BLANK;
            nxt_d   = ST_SMALL;
          end
        end
      end
      ST_DONE:      state_d = ((CONT != 0) && bus.en) ? ST_PRECHARGE : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // Every conversion (first or back-to-back) starts with cleared counters.
    if ((state_d == ST_PRECHARGE) && (state_q != ST_PRECHARGE)) begin
      iter_d = '0;
      ones_d = '0;
    end
    // Timer is reloaded with the duration of whichever phase is being entered.
    load = (state_d != state_q);
    unique case (state_d)
      ST_PRECHARGE:     load_val = TW'(PRECHG_CYC - 1);
      ST_BLANK:         load_val = TW'(BLANK_CYC - 1);
      ST_SMALL, ST_BIG: load_val = TW'(SETTLE_CYC - 1);
      default:          load_val = '0;
    endcase
  end

  always_comb begin
    // Switches follow the next state so the registered outputs line up with state_q.
    pre_d   = (state_d == ST_PRECHARGE);
    phi_s_d = (state_d == ST_SMALL);
    phi_b_d = (state_d == ST_BIG);
    p1_d    = p1_q;
    if ((state_d == ST_SMALL) && (state_q != ST_SMALL)) p1_d = ~p1_q;
    p2_d    = ~p1_d;
    src_n_d = ~(sample && bus.cmp);
    snk_d   = sample && !bus.cmp;
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_q == ST_DONE);
    result_d    = result_q;
    result_ch_d = result_ch_q;
    ch_idx_d    = ch_idx_q;
    ch_sel_d    = ch_sel_q;
    if (state_q == ST_DONE) begin
      result_d    = ones_q;
      result_ch_d = ch_idx_q;
      ch_idx_d    = (ch_idx_q == CW'(NCH - 1)) ? '0 : ch_idx_q + 1'b1;
      for (int i = 0; i < NCH; i++) ch_sel_d[i] = (ch_idx_d == CW'(i));
    end
  end

  assign bus.ch_sel    = ch_sel_q;
  assign bus.pre_chrg  = pre_q;
  assign bus.phi_s     = phi_s_q;
  assign bus.phi_b     = phi_b_q;
  assign bus.cmp_p1    = p1_q;
  assign bus.cmp_p2    = p2_q;
  assign bus.src_n     = src_n_q;
  assign bus.snk       = snk_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.result    = result_q;
  assign bus.result_ch = result_ch_q;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// tb/tb_tmp_seq_ctrl.sv - scoreboard bench for tmp_seq_ctrl in three configurations
module tb_tmp_seq_ctrl;

  typedef struct {
    int result;
    int ch;
    int src;
    int snk;
    int lat;
    int chsel;
    int busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b, reset_c;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mode_a = 0;
  int   lat[3], nsrc[3], nsnk[3], inv[3];
  bit   bprev[3];
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  tmp_seq_ctrl_if #(.NCH(1), .N_CONV(64)) ifa ();
  tmp_seq_ctrl_if #(.NCH(3), .N_CONV(4))  ifb ();
  tmp_seq_ctrl_if #(.NCH(2), .N_CONV(5))  ifc ();

  tmp_seq_ctrl dut_a (.clk(clk), .reset(reset_a), .bus(ifa));

  tmp_seq_ctrl #(.PRECHG_CYC(3), .SETTLE_CYC(1), .BLANK_CYC(1), .N_CONV(4), .NCH(3), .CONT(1))
    dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

  tmp_seq_ctrl #(.PRECHG_CYC(2), .SETTLE_CYC(3), .BLANK_CYC(2), .N_CONV(5), .NCH(2), .CONT(0))
    dut_c (.clk(clk), .reset(reset_c), .bus(ifc));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit pop(input int id, output exp_t e);
    e = '{0, 0, 0, 0, 0, 0, 0};
    case (id)
      0: if (q_a.size() != 0) begin e = q_a.pop_front(); return 1'b1; end
      1: if (q_b.size() != 0) begin e = q_b.pop_front(); return 1'b1; end
      default: if (q_c.size() != 0) begin e = q_c.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  task automatic mon(input int id, input string tag, input logic rst, pre, phs, phb, p1, p2,
                     srcn, snks, busy, valid, input int res, ch, chsel);
    exp_t e;
    if (rst) begin
      lat[id] = 0; nsrc[id] = 0; nsnk[id] = 0; bprev[id] = 1'b0;
      return;
    end
    lat[id]++;
    if (busy && !bprev[id]) begin
      lat[id] = 0; nsrc[id] = 0; nsnk[id] = 0;
    end
    bprev[id] = busy;
    if (!srcn) nsrc[id]++;
    if (snks) nsnk[id]++;
    if ((phs && phb) || (pre && (phs || phb)) || (!srcn && snks) || (p1 == p2)) inv[id]++;
    if (valid) begin
      if (pop(id, e)) begin
        chk({tag, ".result"},    res,      e.result);
        chk({tag, ".result_ch"}, ch,       e.ch);
        chk({tag, ".src_pulses"}, nsrc[id], e.src);
        chk({tag, ".snk_pulses"}, nsnk[id], e.snk);
        chk({tag, ".latency"},   lat[id],  e.lat);
        chk({tag, ".ch_sel"},    chsel,    e.chsel);
        chk({tag, ".busy_at_valid"}, busy, e.busy);
      end else begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.unexpected_valid: got valid=1 required no strobe", tag);
      end
      lat[id] = 0; nsrc[id] = 0; nsnk[id] = 0;
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, "a", reset_a, ifa.pre_chrg, ifa.phi_s, ifa.phi_b, ifa.cmp_p1, ifa.cmp_p2, ifa.src_n,
        ifa.snk, ifa.busy, ifa.valid, int'(ifa.result), int'(ifa.result_ch), int'(ifa.ch_sel));
    mon(1, "b", reset_b, ifb.pre_chrg, ifb.phi_s, ifb.phi_b, ifb.cmp_p1, ifb.cmp_p2, ifb.src_n,
        ifb.snk, ifb.busy, ifb.valid, int'(ifb.result), int'(ifb.result_ch), int'(ifb.ch_sel));
    mon(2, "c", reset_c, ifc.pre_chrg, ifc.phi_s, ifc.phi_b, ifc.cmp_p1, ifc.cmp_p2, ifc.src_n,
        ifc.snk, ifc.busy, ifc.valid, int'(ifc.result), int'(ifc.result_ch), int'(ifc.ch_sel));
  end

  // Comparator driver for dut_a: constant 1, toggle after every balance pulse, or constant 0.
  initial begin
    ifa.cmp = 1'b1;
    forever begin
      @(negedge clk);
      case (mode_a)
        0: ifa.cmp = 1'b1;
        1: if (!ifa.src_n || ifa.snk) ifa.cmp = ~ifa.cmp;
        default: ifa.cmp = 1'b0;
      endcase
    end
  end

  task automatic chk_rst_a(input string tag);
    chk({tag, ".outputs"}, int'({ifa.ch_sel, ifa.pre_chrg, ifa.phi_s, ifa.phi_b, ifa.cmp_p1,
        ifa.cmp_p2, ifa.src_n, ifa.snk, ifa.busy, ifa.valid}), 10'b1000011000);
    chk({tag, ".result"}, int'(ifa.result), 0);
    chk({tag, ".result_ch"}, int'(ifa.result_ch), 0);
  endtask

  task automatic stim_a();
    int busy_seen;
    reset_a = 1'b1; ifa.en = 1'b0; mode_a = 0;
    repeat (3) @(negedge clk);
    chk_rst_a("a_reset");
    reset_a = 1'b0;
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifa.busy) busy_seen++;
    end
    chk("a_idle_busy_cycles", busy_seen, 0);
    chk_rst_a("a_idle");
    q_a.push_back('{64, 0, 64, 0, 396, 1, 1});
    q_a.push_back('{32, 0, 32, 32, 396, 1, 1});
    ifa.en = 1'b1;
    repeat (397) @(negedge clk);
    mode_a = 1;
    repeat (396) @(negedge clk);
    repeat (150) @(negedge clk);
    chk("a_busy_mid_conv", int'(ifa.busy), 1);
    reset_a = 1'b1; mode_a = 2;
    @(negedge clk);
    chk_rst_a("a_abort");
    @(negedge clk);
    q_a.push_back('{0, 0, 0, 64, 396, 1, 0});
    reset_a = 1'b0;
    repeat (20) @(negedge clk);
    ifa.en = 1'b0;
    repeat (390) @(negedge clk);
    chk("a_idle_after_en_drop", int'(ifa.busy), 0);
  endtask

  task automatic stim_b();
    reset_b = 1'b1; ifb.en = 1'b0; ifb.cmp = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_reset_ch_sel", int'(ifb.ch_sel), 1);
    chk("b_reset_busy", int'(ifb.busy), 0);
    reset_b = 1'b0;
    q_b.push_back('{4, 0, 4, 0, 20, 2, 1});
    q_b.push_back('{4, 1, 4, 0, 20, 4, 1});
    q_b.push_back('{4, 2, 4, 0, 20, 1, 1});
    q_b.push_back('{4, 0, 4, 0, 20, 2, 0});
    ifb.en = 1'b1;
    repeat (70) @(negedge clk);
    ifb.en = 1'b0;
    repeat (30) @(negedge clk);
    chk("b_idle_after", int'(ifb.busy), 0);
    chk("b_ch_sel_final", int'(ifb.ch_sel), 2);
  endtask

  task automatic stim_c();
    reset_c = 1'b1; ifc.en = 1'b0; ifc.cmp = 1'b1;
    repeat (3) @(negedge clk);
    reset_c = 1'b0;
    q_c.push_back('{5, 0, 5, 0, 53, 2, 0});
    ifc.en = 1'b1;
    repeat (10) @(negedge clk);
    ifc.en = 1'b0;
    repeat (60) @(negedge clk);
    chk("c_idle_after_single", int'(ifc.busy), 0);
    ifc.cmp = 1'b0;
    q_c.push_back('{0, 1, 0, 5, 53, 1, 0});
    ifc.en = 1'b1;
    repeat (54) @(negedge clk);
    ifc.en = 1'b0;
    repeat (20) @(negedge clk);
    chk("c_idle_final", int'(ifc.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; nsrc[i] = 0; nsnk[i] = 0; inv[i] = 0; bprev[i] = 1'b0;
    end
    fork
      stim_a();
      stim_b();
      stim_c();
    join
    chk("a_pending_results", q_a.size(), 0);
    chk("b_pending_results", q_b.size(), 0);
    chk("c_pending_results", q_c.size(), 0);
    chk("a_phase_violations", inv[0], 0);
    chk("b_phase_violations", inv[1], 0);
    chk("c_phase_violations", inv[2], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
